// File: rtl/mfp_als_spi_pkg.sv
// Shared types and frame layout for the ambient-light-sensor SPI controller.
// The ADC frame carries 3 leading zeros, 8 data bits (MSB first) and 5 trailing zeros.
package mfp_als_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int DATA_MSB   = 12;
    localparam int DATA_LSB   = 5;
    localparam int LEAD_BITS  = 3;
    localparam int TRAIL_BITS = 5;

endpackage

// File: rtl/mfp_als_spi_tick_gen.sv
// Auto-trigger timer: counts 0..PERIOD-1 while enabled and pulses tick on the wrap cycle.
// PERIOD of 0 disables the tick entirely.
module mfp_als_spi_tick_gen #(
    parameter int PERIOD = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2((PERIOD > 1) ? PERIOD : 2);
    localparam logic [CW-1:0] LAST = CW'((PERIOD > 0) ? PERIOD - 1 : 0);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (PERIOD > 0) && enable && (count == LAST);

endmodule

// File: rtl/mfp_als_spi_controller.sv
// Periodic SPI master for the ALS ADC: frames a 16-clock conversion, samples SDO on
// SCK rising edges and publishes the 8-bit result with a one-cycle valid strobe.
//
// state | meaning
// IDLE  | waiting for start, pending or timer tick
// SETUP | CS low, SCK high, CLK_DIV cycles before the first falling edge
// SHIFT | 16 SCK periods (low CLK_DIV, high CLK_DIV), sample on each rise
// HOLD  | CS high quiet time of CLK_DIV cycles
// DONE  | result registered, valid high for one cycle
module mfp_als_spi_controller
    import mfp_als_spi_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int PERIOD  = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       auto_en,
    output logic       spi_cs,
    output logic       spi_sck,
    input  logic       spi_sdo,
    output logic       busy,
    output logic [7:0] value,
    output logic       valid,
    output logic       frame_err
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LOAD = BW'(FRAME_BITS - 1);

    state_t                state;
    state_t                state_next;
    logic [DW-1:0]         div_cnt;
    logic [BW-1:0]         bit_cnt;
    logic                  phase;
    logic [FRAME_BITS-1:0] shreg;
    logic                  sdo_meta;
    logic                  sdo_sync;
    logic                  pending;
    logic                  tick;
    logic                  trigger;
    logic                  div_done;

    mfp_als_spi_tick_gen #(
        .PERIOD(PERIOD)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .enable(auto_en),
        .tick  (tick)
    );

    assign div_done = (div_cnt == '0);

    always_comb begin
        state_next = state;
        trigger    = start | pending | tick;
        spi_cs     = 1'b1;
        spi_sck    = 1'b1;
        busy       = 1'b0;
        valid      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trigger) state_next = ST_SETUP;
            end
            ST_SETUP: begin
                spi_cs = 1'b0;
                busy   = 1'b1;
                if (div_done) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                spi_cs  = 1'b0;
                spi_sck = phase;
                busy    = 1'b1;
                if (div_done && phase && (bit_cnt == '0)) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                busy = 1'b1;
                if (div_done) state_next = ST_DONE;
            end
            ST_DONE: begin
                valid      = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            phase     <= 1'b0;
            shreg     <= '0;
            sdo_meta  <= 1'b0;
            sdo_sync  <= 1'b0;
            pending   <= 1'b0;
            value     <= '0;
            frame_err <= 1'b0;
        end else begin
            state    <= state_next;
            sdo_meta <= spi_sdo;
            sdo_sync <= sdo_meta;

            // Every state change and every SCK phase boundary restarts the half-period timer.
            if (state != state_next) begin
                div_cnt <= DIV_LOAD;
            end else if (state == ST_SHIFT && div_done) begin
                div_cnt <= DIV_LOAD;
            end else if (!div_done) begin
                div_cnt <= div_cnt - 1'b1;
            end

            if (state == ST_SETUP) begin
                phase   <= 1'b0;
                bit_cnt <= BIT_LOAD;
            end else if (state == ST_SHIFT && div_done) begin
                phase <= ~phase;
                if (phase) begin
                    bit_cnt <= bit_cnt - 1'b1;
                end else begin
                    shreg <= {shreg[FRAME_BITS-2:0], sdo_sync};
                end
            end

            if (state == ST_HOLD && div_done) begin
                value     <= shreg[DATA_MSB:DATA_LSB];
                frame_err <= (|shreg[FRAME_BITS-1 -: LEAD_BITS]) | (|shreg[TRAIL_BITS-1:0]);
            end

            // A tick that lands outside IDLE is remembered once; IDLE consumes it immediately.
            if (!auto_en) begin
                pending <= 1'b0;
            end else if (state == ST_IDLE) begin
                pending <= 1'b0;
            end else if (tick) begin
                pending <= 1'b1;
            end
        end
    end

endmodule
